conv_frame_feeder: RTL

Transmit-side driver for the 4×4 convolution engine's input stream. Software or an upstream DMA loads one 4×4 kernel and one 4-row × 64-column feature-map strip into a local byte buffer. On a start request, the block replays the buffer as one 34-cycle frame on eight 8-bit lanes, framed by a start/valid level, in exactly the order the convolution engine consumes it.

---
 rtl/conv_frame_feeder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/conv_frame_feeder.sv
// Frame feeder for the 4x4 convolution engine: buffers one kernel plus one 4x64 strip
// and replays it as a 34-cycle, 8-lane frame on request, optionally chained back-to-back.
module conv_frame_feeder #(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 34,
    parameter int NUM_COLS  = 2*FRAME_LEN-4,
    parameter int ADDR_W    = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              wr_err,
    output logic              out_start_conv,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_data3,
    output logic [DATA_W-1:0] out_data4,
    output logic [DATA_W-1:0] out_data5,
    output logic [DATA_W-1:0] out_data6,
    output logic [DATA_W-1:0] out_data7
);

    localparam int BUF_BYTES = 16 + 4*NUM_COLS;
    localparam int CYC_W     = $clog2(FRAME_LEN);
    localparam int LANES     = 8;
    localparam logic [CYC_W-1:0]  LAST_CYC  = CYC_W'(FRAME_LEN-1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BUF_BYTES-1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic              go_d;
    logic              frame_q, done_q, wr_err_q;
    logic              wr_ok;
    logic [ADDR_W-1:0] base_d;
    logic [DATA_W-1:0] lane_q [LANES];
    logic [DATA_W-1:0] lane_d [LANES];
    logic [DATA_W-1:0] mem    [BUF_BYTES];

    assign wr_ok = wr_en && (state_q == IDLE) && (wr_addr <= LAST_ADDR);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Sequencing: every frame word k occupies buffer bytes 8k..8k+7, kernel included.
    always_comb begin
        go_d  = 1'b0;
        cyc_d = '0;
        case (state_q)
            IDLE: go_d = start;
            SEND: begin
                if (cyc_q == LAST_CYC) begin
                    go_d = start;
                end else begin
                    go_d  = 1'b1;
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: go_d = 1'b0;
        endcase
        base_d = ADDR_W'({cyc_d, 3'b000});
        for (int i = 0; i < LANES; i++) begin
            lane_d[i] = '0;
            if (go_d) begin
                // Same-edge write forwarding so a write coinciding with start is seen.
                if (wr_ok && (wr_addr == base_d + ADDR_W'(i))) begin
                    lane_d[i] = wr_data;
                end else begin
                    lane_d[i] = mem[base_d + ADDR_W'(i)];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cyc_q    <= '0;
            frame_q  <= 1'b0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            state_q  <= go_d ? SEND : IDLE;
            cyc_q    <= cyc_d;
            frame_q  <= go_d;
            done_q   <= go_d && (cyc_d == LAST_CYC);
            wr_err_q <= wr_en && !wr_ok;
            for (int i = 0; i < LANES; i++) begin
                lane_q[i] <= lane_d[i];
            end
        end
    end

    assign busy           = frame_q;
    assign out_start_conv = frame_q;
    assign done           = done_q;
    assign wr_err         = wr_err_q;
    assign out_data0      = lane_q[0];
    assign out_data1      = lane_q[1];
    assign out_data2      = lane_q[2];
    assign out_data3      = lane_q[3];
    assign out_data4      = lane_q[4];
    assign out_data5      = lane_q[5];
    assign out_data6      = lane_q[6];
    assign out_data7      = lane_q[7];

endmodule
